// File: rtl/xor2_resp_checker_if.sv
// Stimulus/response bundle between a 2-input XOR gate under test and its checker.
// The master drives the stimulus and the gate output; the slave checks and reports.
interface xor2_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             a;
    logic             b;
    logic             c;
    logic             chk_valid;
    logic             chk_err;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0]       seen;
    logic             done;
    logic             pass;

    modport master (
        output en, clr, a, b, c,
        input  chk_valid, chk_err, vec_cnt, err_cnt, seen, done, pass
    );

    modport slave (
        input  en, clr, a, b, c,
        output chk_valid, chk_err, vec_cnt, err_cnt, seen, done, pass
    );
endinterface

// File: rtl/xor2_resp_checker.sv
// Response checker for a 2-input XOR gate: waits for (a,b) to settle,
// compares c with a^b once per held vector, and tracks coverage and errors.
module xor2_resp_checker #(
    parameter int SETTLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    xor2_resp_checker_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(SETTLE - 1);

    state_t           r_state;
    logic [1:0]       r_prev;
    logic [7:0]       r_timer;
    logic             r_vld;
    logic             r_err;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [3:0]       r_seen;
    logic             r_done;

    logic [1:0] w_ab;
    logic       w_chg;
    logic       w_mis;
    logic [3:0] w_seen_nx;

    assign w_ab      = {bus.a, bus.b};
    assign w_chg     = (w_ab != r_prev);
    assign w_mis     = bus.c ^ bus.a ^ bus.b;
    assign w_seen_nx = r_seen | (4'b0001 << w_ab);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_prev    <= 2'b00;
            r_timer   <= 8'd0;
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_seen    <= 4'h0;
            r_done    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            if (!bus.en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_prev  <= w_ab;
                        r_timer <= 8'd0;
                        r_state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (w_chg) begin
                            r_prev  <= w_ab;
                            r_timer <= 8'd0;
                        end else if (r_timer == LP_LAST) begin
                            r_state <= S_SAMPLE;
                        end else begin
                            r_timer <= r_timer + 8'd1;
                        end
                    end
                    S_SAMPLE: begin
                        if (w_chg) begin
                            r_prev  <= w_ab;
                            r_timer <= 8'd0;
                            r_state <= S_SETTLE;
                        end else begin
                            r_vld  <= 1'b1;
                            r_err  <= w_mis;
                            r_seen <= w_seen_nx;
                            r_done <= r_done | (&w_seen_nx);
                            if (r_vec_cnt != '1)
                                r_vec_cnt <= r_vec_cnt + 1'b1;
                            if (w_mis && (r_err_cnt != '1))
                                r_err_cnt <= r_err_cnt + 1'b1;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (w_chg) begin
                            r_prev  <= w_ab;
                            r_timer <= 8'd0;
                            r_state <= S_SETTLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            // clear overrides any same-edge update but leaves the pulses alone
            if (bus.clr) begin
                r_vec_cnt <= '0;
                r_err_cnt <= '0;
                r_seen    <= 4'h0;
                r_done    <= 1'b0;
            end
        end
    end

    assign bus.chk_valid = r_vld;
    assign bus.chk_err   = r_err;
    assign bus.vec_cnt   = r_vec_cnt;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.seen      = r_seen;
    assign bus.done      = r_done;
    assign bus.pass      = r_done && (r_err_cnt == '0);
endmodule

// File: tb/tb_xor2_resp_checker.sv
// Directed bench for xor2_resp_checker: good, AND and inverted gates,
// glitch rejection, reset, saturation, en drop and clear.
module tb_xor2_resp_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    int m_mode = 0;
    int s_mode = 2;
    int m_nv = 0;
    int m_ne = 0;
    int s_nv = 0;

    xor2_resp_checker_if #(.CNT_W(8)) m_if ();
    xor2_resp_checker_if #(.CNT_W(2)) s_if ();

    xor2_resp_checker #(.SETTLE(4), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    xor2_resp_checker #(.SETTLE(4), .CNT_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    always #5 clk = ~clk;

    // mode 0: XOR, 1: AND, 2: XNOR (faulty)
    function automatic logic gate(input int mode, input logic x, input logic y);
        case (mode)
            1:       return x & y;
            2:       return ~(x ^ y);
            default: return x ^ y;
        endcase
    endfunction

    assign m_if.c = gate(m_mode, m_if.a, m_if.b);
    assign s_if.c = gate(s_mode, s_if.a, s_if.b);

    always @(negedge clk) begin
        if (m_if.chk_valid) m_nv++;
        if (m_if.chk_err)   m_ne++;
        if (s_if.chk_valid) s_nv++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] ab, input int n);
        m_if.a = ab[1];
        m_if.b = ab[0];
        tick(n);
    endtask

    task automatic put_s(input logic [1:0] ab, input int n);
        s_if.a = ab[1];
        s_if.b = ab[0];
        tick(n);
    endtask

    task automatic pulse_clr();
        m_if.clr = 1'b1;
        tick(1);
        m_if.clr = 1'b0;
    endtask

    int nv0;
    int ne0;
    int cyc;

    initial begin
        m_if.en = 1'b0; m_if.clr = 1'b0; m_if.a = 1'b0; m_if.b = 1'b0;
        s_if.en = 1'b0; s_if.clr = 1'b0; s_if.a = 1'b0; s_if.b = 1'b0;
        tick(2);
        check("rst_vec", m_if.vec_cnt, 0);
        check("rst_err", m_if.err_cnt, 0);
        check("rst_seen", m_if.seen, 0);
        check("rst_done", m_if.done, 0);
        check("rst_pass", m_if.pass, 0);
        check("rst_vld", m_if.chk_valid, 0);
        rst = 1'b0;
        tick(1);

        // good XOR gate, all four vectors
        m_if.en = 1'b1;
        nv0 = m_nv; ne0 = m_ne;
        put(2'b00, 25); put(2'b01, 25); put(2'b10, 25); put(2'b11, 25);
        check("xor_pulses", m_nv - nv0, 4);
        check("xor_errpulses", m_ne - ne0, 0);
        check("xor_vec", m_if.vec_cnt, 4);
        check("xor_err", m_if.err_cnt, 0);
        check("xor_seen", m_if.seen, 15);
        check("xor_done", m_if.done, 1);
        check("xor_pass", m_if.pass, 1);

        // AND gate in place of XOR
        pulse_clr();
        check("clr_done", m_if.done, 0);
        m_mode = 1;
        nv0 = m_nv; ne0 = m_ne;
        put(2'b00, 25); put(2'b01, 25); put(2'b10, 25); put(2'b11, 25);
        check("and_pulses", m_nv - nv0, 4);
        check("and_errpulses", m_ne - ne0, 3);
        check("and_err", m_if.err_cnt, 3);
        check("and_vec", m_if.vec_cnt, 4);
        check("and_done", m_if.done, 1);
        check("and_pass", m_if.pass, 0);

        // short hold is never checked
        m_mode = 0;
        pulse_clr();
        nv0 = m_nv;
        put(2'b01, 3); put(2'b10, 10);
        check("glitch_pulses", m_nv - nv0, 1);
        check("glitch_vec", m_if.vec_cnt, 1);
        check("glitch_seen", m_if.seen, 4);

        // reset two cycles into a hold
        put(2'b11, 2);
        rst = 1'b1;
        #1;
        check("mrst_vec", m_if.vec_cnt, 0);
        check("mrst_seen", m_if.seen, 0);
        check("mrst_vld", m_if.chk_valid, 0);
        tick(1);
        rst = 1'b0;
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (!m_if.chk_valid && cyc < 20);
        check("mrst_latency", cyc, 6);
        check("mrst_seen2", m_if.seen, 8);
        check("mrst_vec2", m_if.vec_cnt, 1);

        // CNT_W=2 saturation with an inverted gate
        s_if.a = 1'b0; s_if.b = 1'b1;
        s_if.en = 1'b1;
        for (int i = 0; i < 6; i++)
            put_s((i % 2) ? 2'b11 : 2'b01, 8);
        check("sat_pulses", s_nv, 6);
        check("sat_err", s_if.err_cnt, 3);
        check("sat_vec", s_if.vec_cnt, 3);
        check("sat_seen", s_if.seen, 10);
        check("sat_pass", s_if.pass, 0);

        // en drop holds counters; clr wins over a same-edge compare
        pulse_clr();
        put(2'b00, 10);
        check("en_vec0", m_if.vec_cnt, 1);
        put(2'b01, 2);
        m_if.en = 1'b0;
        nv0 = m_nv;
        tick(5);
        check("en_hold_vec", m_if.vec_cnt, 1);
        check("en_hold_seen", m_if.seen, 1);
        check("en_hold_pulses", m_nv - nv0, 0);
        m_if.en = 1'b1;
        tick(5);
        m_if.clr = 1'b1;
        tick(1);
        m_if.clr = 1'b0;
        check("clr_vld", m_if.chk_valid, 1);
        check("clr_vec", m_if.vec_cnt, 0);
        check("clr_seen", m_if.seen, 0);
        tick(1);
        check("clr_vld_off", m_if.chk_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/xor2_resp_checker.md
# xor2_resp_checker

Synthesizable response checker for the 2-input XOR gate under test. It is the receiving end of the gate's stimulus/response interface. It watches the stimulus pair (a, b) and the gate output c. After each input change has held stable for a settle window, it samples c and compares it with a ^ b. It counts vectors and mismatches, records which of the four input combinations have been checked, and raises done/pass flags so gate tests run self-checking in simulation and on hardware.

## Interface
- SETTLE, 4: consecutive clock edges with (a, b) unchanged before c is sampled. Legal range 1..255.
- CNT_W, 8: width of vec_cnt and err_cnt.

- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  check enable; level
- clr  in  1  synchronous clear of counters, seen, done and pass; does not change FSM state
- a  in  1  stimulus bit a, as driven to the gate
- b  in  1  stimulus bit b, as driven to the gate
- c  in  1  gate output under check
- chk_valid  out  1  one-cycle pulse: a compare was performed
- chk_err  out  1  one-cycle pulse with chk_valid: c != a ^ b
- vec_cnt  out  CNT_W  vectors checked, saturating
- err_cnt  out  CNT_W  mismatches, saturating
- seen  out  4  bit index {a,b} set once that combination has been checked
- done  out  1  sticky; seen == 4'hF
- pass  out  1  done && err_cnt == 0

## Operation
- Inputs a, b, c are sampled synchronously. The source must be in the clk domain; this block has no synchronizer.
- Internal registers: prev_ab (2 bits), timer (8 bits), state.
- State IDLE:
  - If en=1: load prev_ab <= {a,b}, clear timer, go to SETTLE.
- State SETTLE:
  - If {a,b} != prev_ab: prev_ab <= {a,b}, timer <= 0, stay in SETTLE. This restarts the window, so glitches are never checked.
  - Otherwise timer++. When timer reaches SETTLE-1 on this edge, go to SAMPLE.
- State SAMPLE (one cycle), on the edge leaving it:
  - If {a,b} == prev_ab:
    - Register chk_valid=1 and chk_err = c ^ a ^ b.
    - vec_cnt++, and err_cnt++ if mismatch.
    - seen[{a,b}] <= 1.
    - Go to WAIT_CHG.
  - If {a,b} changed: no compare. Load prev_ab, clear timer, go to SETTLE.
- State WAIT_CHG:
  - If {a,b} != prev_ab: prev_ab <= {a,b}, timer <= 0, go to SETTLE.
  - A held vector is checked exactly once.
- en=0 in any state: go to IDLE on the next edge. Any compare pending that edge is dropped. Counters, seen and done are held.
- Counters saturate at 2^CNT_W-1 and never wrap.
- seen bits and done are sticky until rst or clr.
- clr=1: vec_cnt, err_cnt, seen, done, pass <= 0 on that edge. If a compare occurs on the same edge, clr wins: counters are 0 and chk_valid/chk_err still pulse.
- pass is combinational from the done and err_cnt registers.

## Timing
- Reset values: state=IDLE, prev_ab=0, timer=0, chk_valid=0, chk_err=0, vec_cnt=0, err_cnt=0, seen=0, done=0, pass=0.
- Reset mid-operation: all registers return to reset values immediately, with no partial compare.
- Latency, with en=1 and a new vector first registered at edge E0:
  - compare edge is E0+SETTLE+1;
  - chk_valid is high for the cycle following that edge;
  - vec_cnt, err_cnt and seen update at the same edge;
  - done rises at the same edge as the fourth distinct seen bit.
- Minimum hold for a vector to be checked is SETTLE+1 cycles. Shorter holds produce no compare.
- Back-to-back vectors: at most one compare per SETTLE+2 cycles.

## Test plan
- SETTLE=4, correct XOR model; apply (0,0), (0,1), (1,0), (1,1), each held 25 cycles -> 4 chk_valid pulses, chk_err never high; vec_cnt=4, err_cnt=0, seen=4'hF, done=1, pass=1.
- Same sequence but the gate is an AND -> chk_err pulses on (0,1), (1,0), (1,1); err_cnt=3, done=1, pass=0.
- SETTLE=4; (0,1) held 3 cycles, then (1,0) held 10 cycles -> exactly one compare, for (1,0); seen=4'b0100, vec_cnt=1.
- Assert rst for 1 cycle while in SETTLE, 2 cycles into a hold -> all outputs 0 at once; after release, the vector is checked SETTLE+1 cycles after re-entry from IDLE.
- CNT_W=2, faulty gate; toggle between (0,1) and (1,1) six times -> err_cnt and vec_cnt saturate at 3, no wrap.
- Drop en for 5 cycles mid-run, then pulse clr together with a compare edge -> counters held while en=0; after clr, vec_cnt=0, seen=0, and chk_valid still pulses.
